// File: rtl/motor_cmd_pkg.sv
// Shared types, commutation encodings and frame sizing for the motor command decoder.
package motor_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_COAST = 2'b00,
    CMD_CW    = 2'b01,
    CMD_CCW   = 2'b10,
    CMD_BRAKE = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    ST_COAST,
    ST_RUN_CW,
    ST_RUN_CCW,
    ST_BRAKE,
    ST_REV_WAIT
  } mstate_t;

  // Commutation controller input encoding {brake, ccw, cw}; at most one bit is ever active.
  localparam logic [2:0] CC_COAST = 3'b000;
  localparam logic [2:0] CC_CW    = 3'b001;
  localparam logic [2:0] CC_CCW   = 3'b010;
  localparam logic [2:0] CC_BRAKE = 3'b100;

  // Number of UART bytes needed to carry 2 command bits per motor.
  function automatic int frame_bytes(input int n);
    return (2 * n + 7) / 8;
  endfunction

  // Commutation output for a motor state; the reversal wait brakes the motor.
  function automatic logic [2:0] cc_of(input mstate_t s);
    case (s)
      ST_RUN_CW:   return CC_CW;
      ST_RUN_CCW:  return CC_CCW;
      ST_BRAKE:    return CC_BRAKE;
      ST_REV_WAIT: return CC_BRAKE;
      default:     return CC_COAST;
    endcase
  endfunction

endpackage

// File: rtl/motor_dir_interlock.sv
// Per-motor command FSM with a timed brake inserted on direct CW<->CCW reversal.
module motor_dir_interlock
  import motor_cmd_pkg::*;
#(
  parameter int DEADTIME_CYC = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stb_i,
  input  cmd_t       cmd_i,
  output logic [2:0] cc_o,
  output logic       ilk_o
);

  localparam int CNT_W = (DEADTIME_CYC > 0) ? $clog2(DEADTIME_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEADTIME_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mstate_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_ccw_q, pend_ccw_d;
  logic             want_ccw;
  logic [2:0]       cc_q;
  logic             ilk_q;

  // Next-state: reversal countdown first, then any strobed command overrides it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_ccw_d = pend_ccw_q;
    want_ccw   = (cmd_i == CMD_CCW);
    if (state_q == ST_REV_WAIT) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_ONE) state_d = pend_ccw_q ? ST_RUN_CCW : ST_RUN_CW;
    end
    if (stb_i) begin
      case (cmd_i)
        CMD_COAST: state_d = ST_COAST;
        CMD_BRAKE: state_d = ST_BRAKE;
        default: begin
          case (state_q)
            ST_REV_WAIT: begin
              // Retarget the pending direction but keep the running deadtime.
              pend_ccw_d = want_ccw;
              if (cnt_q == CNT_ONE) state_d = want_ccw ? ST_RUN_CCW : ST_RUN_CW;
            end
            ST_RUN_CW, ST_RUN_CCW: begin
              if (want_ccw != (state_q == ST_RUN_CCW)) begin
                if (DEADTIME_CYC > 0) begin
                  state_d    = ST_REV_WAIT;
                  cnt_d      = CNT_LOAD;
                  pend_ccw_d = want_ccw;
                end else begin
                  state_d = want_ccw ? ST_RUN_CCW : ST_RUN_CW;
                end
              end
            end
            default: state_d = want_ccw ? ST_RUN_CCW : ST_RUN_CW;
          endcase
        end
      endcase
    end
  end

  // State, countdown and registered outputs; reset forces COAST even mid-reversal.
  always_ff @(posedge clk) begin
    cnt_q      <= cnt_d;
    pend_ccw_q <= pend_ccw_d;
    if (rst) begin
      state_q <= ST_COAST;
      cc_q    <= CC_COAST;
      ilk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_of(state_d);
      ilk_q   <= (state_d == ST_REV_WAIT);
    end
  end

  assign cc_o  = cc_q;
  assign ilk_o = ilk_q;

endmodule

// File: rtl/motor_cmd_decoder.sv
// Assembles UART bytes into a motor-command frame and drives one interlock FSM per motor.
// Optional silence watchdog is built when MOTOR_WDOG_EN is defined.
module motor_cmd_decoder
  import motor_cmd_pkg::*;
#(
  parameter int NUM_MOTORS   = 4,
  parameter int DEADTIME_CYC = 50,
  parameter int TIMEOUT_CYC  = 5000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [3*NUM_MOTORS-1:0] cc_in,
  output logic                    cmd_stb,
  output logic [NUM_MOTORS-1:0]   interlock_active,
  output logic                    wdog_trip
);

  localparam int BYTES   = frame_bytes(NUM_MOTORS);
  localparam int FRAME_W = 8 * BYTES;
  localparam int CMD_W   = 2 * NUM_MOTORS;
  localparam int BCNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES - 1);

  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [FRAME_W-1:0] buf_q, buf_d;
  logic [CMD_W-1:0]   frame_q, frame_d;
  logic               stb_q, stb_d;
  logic               eval_q, eval_d;

`ifdef MOTOR_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_TOP  = WD_W'(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_FIRE = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_q;
  logic            wdog_fire;
  logic            trip_q, trip_d;

  assign wdog_fire = !rx_valid && (wd_q == WD_FIRE);

  // Silence counter: cleared by any byte, saturates so a silence period trips once.
  always_ff @(posedge clk) begin
    if (rst || rx_valid) wd_q <= '0;
    else if (wd_q != WD_TOP) wd_q <= wd_q + 1'b1;
  end

  assign wdog_trip = trip_q;
`else
  assign wdog_trip = 1'b0;
`endif

  // Byte assembly; a frame only becomes visible once its last byte arrives.
  always_comb begin
    bcnt_d  = bcnt_q;
    buf_d   = buf_q;
    frame_d = frame_q;
    stb_d   = 1'b0;
    eval_d  = 1'b0;
    if (rx_valid) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bcnt_q == BCNT_W'(b)) buf_d[8*b +: 8] = rx_data;
      end
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d  = '0;
        frame_d = buf_d[CMD_W-1:0];
        stb_d   = 1'b1;
        eval_d  = 1'b1;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
`ifdef MOTOR_WDOG_EN
    trip_d = trip_q;
    if (stb_q) trip_d = 1'b0;
    // Forced all-BRAKE frame also realigns byte framing.
    if (wdog_fire) begin
      bcnt_d  = '0;
      frame_d = '1;
      eval_d  = 1'b1;
      trip_d  = 1'b1;
    end
`endif
  end

  // Frame, strobe and framing registers; the byte buffer is pure data and is not reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    if (rst) begin
      bcnt_q  <= '0;
      frame_q <= '0;
      stb_q   <= 1'b0;
      eval_q  <= 1'b0;
`ifdef MOTOR_WDOG_EN
      trip_q  <= 1'b0;
`endif
    end else begin
      bcnt_q  <= bcnt_d;
      frame_q <= frame_d;
      stb_q   <= stb_d;
      eval_q  <= eval_d;
`ifdef MOTOR_WDOG_EN
      trip_q  <= trip_d;
`endif
    end
  end

  assign cmd_stb = stb_q;

  // Spare command bits in the last byte carry no motor.
  if (FRAME_W > CMD_W) begin : g_spare
    logic unused_spare_bits;
    assign unused_spare_bits = ^buf_q[FRAME_W-1:CMD_W];
  end

  for (genvar m = 0; m < NUM_MOTORS; m++) begin : g_motor
    motor_dir_interlock #(
      .DEADTIME_CYC(DEADTIME_CYC)
    ) u_ilk (
      .clk   (clk),
      .rst   (rst),
      .stb_i (eval_q),
      .cmd_i (cmd_t'(frame_q[2*m +: 2])),
      .cc_o  (cc_in[3*m +: 3]),
      .ilk_o (interlock_active[m])
    );
  end

endmodule

// File: tb/tb_motor_cmd_decoder.sv
// Directed bench: a 4-motor/8-cycle-deadtime decoder and a 6-motor/no-deadtime decoder.
module tb_motor_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data4 = 8'h00, rx_data6 = 8'h00;
  logic        rx_valid4 = 1'b0, rx_valid6 = 1'b0;
  logic [11:0] cc4;
  logic [17:0] cc6;
  logic        cs4, cs6, wt4, wt6;
  logic [3:0]  il4;
  logic [5:0]  il6;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic [11:0] cc;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  motor_cmd_decoder #(.NUM_MOTORS(4), .DEADTIME_CYC(8), .TIMEOUT_CYC(5000000)) dut4 (
    .clk(clk), .rst(rst), .rx_data(rx_data4), .rx_valid(rx_valid4),
    .cc_in(cc4), .cmd_stb(cs4), .interlock_active(il4), .wdog_trip(wt4));

  motor_cmd_decoder #(.NUM_MOTORS(6), .DEADTIME_CYC(0), .TIMEOUT_CYC(100)) dut6 (
    .clk(clk), .rst(rst), .rx_data(rx_data6), .rx_valid(rx_valid6),
    .cc_in(cc6), .cmd_stb(cs6), .interlock_active(il6), .wdog_trip(wt6));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns at the falling edge after the byte was sampled (cmd_stb visible here).
  task automatic send4(input logic [7:0] b);
    @(negedge clk); rx_data4 = b; rx_valid4 = 1'b1;
    @(negedge clk); rx_valid4 = 1'b0;
  endtask

  task automatic send6(input logic [7:0] b);
    @(negedge clk); rx_data6 = b; rx_valid6 = 1'b1;
    @(negedge clk); rx_valid6 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int i;
    tbl[0] = '{8'hE4, 12'h888};
    tbl[1] = '{8'h00, 12'h000};
    tbl[2] = '{8'hFF, 12'h924};
    tbl[3] = '{8'h55, 12'h249};
    tbl[4] = '{8'h55, 12'h249};
    tbl[5] = '{8'h00, 12'h000};
    tbl[6] = '{8'hAA, 12'h492};
    tbl[7] = '{8'h8E, 12'h422};
    tbl[8] = '{8'h17, 12'h04C};

    // Reset held with byte strobes toggling.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rx_valid4 = ~rx_valid4; rx_valid6 = ~rx_valid6;
      rx_data4 = 8'hFF; rx_data6 = 8'hAA;
    end
    @(negedge clk);
    chk("rst_cc4", 32'(cc4), 32'h0);
    chk("rst_il4", 32'(il4), 32'h0);
    chk("rst_cs4", 32'(cs4), 32'h0);
    chk("rst_cc6", 32'(cc6), 32'h0);
    chk("rst_cs6", 32'(cs6), 32'h0);
    chk("rst_wt6", 32'(wt6), 32'h0);
    rst = 1'b0; rx_valid4 = 1'b0; rx_valid6 = 1'b0;

    // 6-motor two-byte frame: first byte alone changes nothing.
    send6(8'h55);
    chk("m6_partial_stb", 32'(cs6), 32'h0);
    @(negedge clk);
    chk("m6_partial_cc", 32'(cc6), 32'h0);
    send6(8'h0A);
    chk("m6_full_stb", 32'(cs6), 32'h1);
    @(negedge clk);
    chk("m6_full_cc", 32'(cc6), 32'h12249);
    chk("m6_stb_single", 32'(cs6), 32'h0);
    // Zero deadtime: CW -> CCW without brake.
    send6(8'h56);
    send6(8'h0A);
    @(negedge clk);
    chk("m6_dt0_cc", 32'(cc6), 32'h1224A);
    chk("m6_dt0_il", 32'(il6), 32'h0);

    // Table of single-byte frames for the 4-motor decoder.
    foreach (tbl[k]) begin
      send4(tbl[k].data);
      chk($sformatf("tbl%0d_stb", k), 32'(cs4), 32'h1);
      @(negedge clk);
      chk($sformatf("tbl%0d_cc", k), 32'(cc4), 32'(tbl[k].cc));
      chk($sformatf("tbl%0d_il", k), 32'(il4), 32'h0);
    end

    // Reversal CW -> CCW: brake for exactly 8 cycles.
    send4(8'h01);
    @(negedge clk);
    chk("rev_cw", 32'(cc4), 32'h001);
    send4(8'h02);
    @(negedge clk);
    n = 0;
    while (cc4[2:0] == 3'b100 && il4[0] && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("rev_brake_len", 32'(n), 32'd8);
    chk("rev_end_cc", 32'(cc4), 32'h002);
    chk("rev_end_il", 32'(il4), 32'h0);

    // Reversal CCW -> CW, retargeted to CCW mid-wait: no extra brake cycles.
    send4(8'h01);
    @(negedge clk);
    n = 0; i = 0;
    while (cc4[2:0] == 3'b100 && il4[0] && n < 40) begin
      n++;
      if (i == 2) begin rx_data4 = 8'h02; rx_valid4 = 1'b1; end
      else rx_valid4 = 1'b0;
      i++;
      @(negedge clk);
    end
    rx_valid4 = 1'b0;
    chk("retarget_len", 32'(n), 32'd8);
    chk("retarget_cc", 32'(cc4), 32'h002);

    // Abort the wait with COAST.
    send4(8'h01);
    @(negedge clk);
    chk("abort_wait_il", 32'(il4), 32'h1);
    chk("abort_wait_cc", 32'(cc4), 32'h004);
    send4(8'h00);
    @(negedge clk);
    chk("abort_cc", 32'(cc4), 32'h000);
    chk("abort_il", 32'(il4), 32'h0);
    repeat (10) @(negedge clk);
    chk("abort_hold_cc", 32'(cc4), 32'h000);

    // Reset in the middle of a reversal wait.
    send4(8'h01);
    send4(8'h02);
    @(negedge clk);
    chk("rstwait_il_pre", 32'(il4), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwait_cc", 32'(cc4), 32'h000);
    chk("rstwait_il", 32'(il4), 32'h0);
    repeat (10) @(negedge clk);
    chk("rstwait_hold_cc", 32'(cc4), 32'h000);
    chk("wt4_idle", 32'(wt4), 32'h0);

`ifdef MOTOR_WDOG_EN
    // Watchdog: frame, then silence until the forced all-BRAKE frame.
    send6(8'h05);
    send6(8'h00);
    chk("wd_frame_stb", 32'(cs6), 32'h1);
    @(negedge clk);
    chk("wd_frame_cc", 32'(cc6), 32'h00009);
    chk("wd_pre_trip", 32'(wt6), 32'h0);
    n = 1;
    while (!wt6 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wd_trip_cycles", 32'(n), 32'd100);
    @(negedge clk);
    chk("wd_brake_cc", 32'(cc6), 32'h24924);
    // Lone first byte, then timeout must resynchronise framing.
    send6(8'h55);
    chk("wd_lone_stb", 32'(cs6), 32'h0);
    repeat (120) @(negedge clk);
    chk("wd_sticky", 32'(wt6), 32'h1);
    send6(8'hAA);
    chk("wd_resync_b0_stb", 32'(cs6), 32'h0);
    send6(8'h05);
    chk("wd_resync_stb", 32'(cs6), 32'h1);
    chk("wd_trip_until_stb", 32'(wt6), 32'h1);
    @(negedge clk);
    chk("wd_resync_cc", 32'(cc6), 32'h09492);
    chk("wd_trip_clear", 32'(wt6), 32'h0);
`else
    repeat (150) @(negedge clk);
    chk("wt6_tied", 32'(wt6), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
